// File: rtl/tb_survivor_writer_pkg.sv
// viterbi_pkg: shared mode encodings, FSM states and word width for the survivor writer
package viterbi_pkg;
  localparam int TB_WORD_W = 64;
  typedef enum logic [1:0] {MODE_K7 = 2'b00, MODE_K6 = 2'b01, MODE_K5 = 2'b10, MODE_K4 = 2'b11} mode_e;
  typedef enum logic [1:0] {IDLE, RUN, PEND, FIN} wr_state_e;
  function automatic logic [2:0] beats_per_step(input logic [1:0] mode);
    return mode == MODE_K7 ? 3'd4 : mode == MODE_K6 ? 3'd2 : 3'd1;
  endfunction
endpackage

// File: rtl/tb_survivor_writer_if.sv
// tb_survivor_writer_if: ACS-to-writer decision beat channel
interface tb_survivor_writer_if #(parameter int W_DEC = 16);
  logic             dec_valid;
  logic             dec_ready;
  logic [W_DEC-1:0] dec;
  logic [5:0]       best_state;
  logic             frame_last;
  modport master (output dec_valid, dec, best_state, frame_last, input dec_ready);
  modport slave (input dec_valid, dec, best_state, frame_last, output dec_ready);
endinterface

// File: rtl/tb_survivor_writer_packer.sv
// tb_word_packer: assembles decision beats into one 64-bit word per trellis step
module tb_word_packer
  import viterbi_pkg::*;
#(
  parameter int W_DEC = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_an_i,
  input  logic                 i_clear,
  input  logic                 i_beat,
  input  logic [1:0]           i_mode,
  input  logic [W_DEC-1:0]     i_dec,
  output logic                 o_last,
  output logic [TB_WORD_W-1:0] o_word
);
  logic [1:0]           r_beat_cnt;
  logic [TB_WORD_W-1:0] r_asm;
  logic [W_DEC-1:0]     w_dec;
  // 8-state mode only carries 8 decisions in the low byte
  assign w_dec  = i_mode == MODE_K4 ? i_dec & W_DEC'(8'hFF) : i_dec;
  assign o_word = r_asm | (TB_WORD_W'(w_dec) << (r_beat_cnt * W_DEC));
  assign o_last = i_beat && ({1'b0, r_beat_cnt} + 3'd1 == beats_per_step(i_mode));
  always_ff @(posedge clk_i or negedge rst_an_i)
    if (!rst_an_i) begin
      r_beat_cnt <= '0;
      r_asm      <= '0;
    end else if (i_clear || o_last) begin
      r_beat_cnt <= '0;
      r_asm      <= '0;
    end else if (i_beat) begin
      r_beat_cnt <= r_beat_cnt + 2'd1;
      r_asm      <= o_word;
    end
endmodule

// File: rtl/tb_survivor_writer.sv
// tb_survivor_writer: packs survivor decisions into the circular traceback RAM and schedules traceback segments.
// Optional TB_SURVIVOR_WRITER_STATS_EN adds steps_written_o / stall_cycles_o counters.
module tb_survivor_writer
  import viterbi_pkg::*;
#(
  parameter int W_TB_LEN  = 6,
  parameter int W_DEC     = 16,
  parameter int TB_DEPTH  = 24,
  parameter int SEG_STEPS = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_an_i,
  input  logic                 rst_sync_i,
  input  logic                 frame_start_i,
  input  logic [1:0]           register_num_i,
  tb_survivor_writer_if.slave  dec_if,
  input  logic                 tb_busy_i,
  output logic                 tb_we_o,
  output logic [W_TB_LEN-1:0]  tb_waddr_o,
  output logic [TB_WORD_W-1:0] tb_wdata_o,
  output logic                 segment_start_o,
  output logic [W_TB_LEN-1:0]  tb_start_addr_o,
  output logic [W_TB_LEN-1:0]  tb_len_o,
  output logic [5:0]           start_state_index_o,
  output logic                 decoding_end_o,
  output logic [1:0]           register_num_o,
  output logic                 frame_done_o
`ifdef TB_SURVIVOR_WRITER_STATS_EN
  ,
  output logic [15:0]          steps_written_o,
  output logic [15:0]          stall_cycles_o
`endif
);
  localparam logic [W_TB_LEN-1:0] FULL  = W_TB_LEN'(TB_DEPTH + SEG_STEPS);
  localparam logic [W_TB_LEN-1:0] SEG   = W_TB_LEN'(SEG_STEPS);
  localparam logic [W_TB_LEN-1:0] DEPTH = W_TB_LEN'(TB_DEPTH);
  typedef struct packed {
    wr_state_e            state;
    logic [1:0]           mode;
    logic [W_TB_LEN-1:0]  wr_ptr;
    logic [W_TB_LEN-1:0]  fill;
    logic [W_TB_LEN-1:0]  seg;
    logic [W_TB_LEN-1:0]  waddr;
    logic [W_TB_LEN-1:0]  start_addr;
    logic [W_TB_LEN-1:0]  len;
    logic [TB_WORD_W-1:0] wdata;
    logic [5:0]           best;
    logic [5:0]           start_state;
    logic                 we;
    logic                 seg_start;
    logic                 dec_end;
    logic                 done;
`ifdef TB_SURVIVOR_WRITER_STATS_EN
    logic [15:0]          steps;
    logic [15:0]          stall;
`endif
  } regs_t;
  regs_t                r_q;
  logic                 w_beat, w_last, w_clear;
  logic [TB_WORD_W-1:0] w_word;
  logic [W_TB_LEN-1:0]  w_fill_n, w_seg_n;
  assign dec_if.dec_ready = r_q.state == RUN;
  assign w_beat   = dec_if.dec_valid && dec_if.dec_ready;
  assign w_clear  = rst_sync_i || r_q.state == IDLE;
  // seg saturates at SEG_STEPS so the first launch fires as soon as the window fills
  assign w_fill_n = r_q.fill == FULL ? r_q.fill : r_q.fill + 1'b1;
  assign w_seg_n  = r_q.seg == SEG ? r_q.seg : r_q.seg + 1'b1;
  tb_word_packer #(.W_DEC(W_DEC)) u_packer (
    .clk_i    (clk_i),
    .rst_an_i (rst_an_i),
    .i_clear  (w_clear),
    .i_beat   (w_beat),
    .i_mode   (r_q.mode),
    .i_dec    (dec_if.dec),
    .o_last   (w_last),
    .o_word   (w_word)
  );
  always_ff @(posedge clk_i or negedge rst_an_i)
    if (!rst_an_i) r_q <= '0;
    else if (rst_sync_i) r_q <= '0;
    else begin
      r_q.we        <= 1'b0;
      r_q.seg_start <= 1'b0;
      r_q.done      <= r_q.seg_start && r_q.dec_end;
`ifdef TB_SURVIVOR_WRITER_STATS_EN
      r_q.steps     <= r_q.we && r_q.steps != 16'hFFFF ? r_q.steps + 16'd1 : r_q.steps;
      r_q.stall     <= (r_q.state == PEND || r_q.state == FIN) && tb_busy_i && r_q.stall != 16'hFFFF ? r_q.stall + 16'd1 : r_q.stall;
`endif
      case (r_q.state)
        IDLE: if (frame_start_i) begin
          r_q.mode   <= register_num_i;
          r_q.wr_ptr <= '0;
          r_q.fill   <= '0;
          r_q.seg    <= '0;
          r_q.state  <= RUN;
`ifdef TB_SURVIVOR_WRITER_STATS_EN
          r_q.steps  <= '0;
          r_q.stall  <= '0;
`endif
        end
        RUN: if (w_last) begin
          r_q.we     <= 1'b1;
          r_q.waddr  <= r_q.wr_ptr;
          r_q.wdata  <= w_word;
          r_q.wr_ptr <= r_q.wr_ptr + 1'b1;
          r_q.fill   <= w_fill_n;
          r_q.seg    <= w_seg_n;
          r_q.best   <= dec_if.best_state;
          r_q.state  <= dec_if.frame_last ? FIN : (w_fill_n == FULL && w_seg_n == SEG) ? PEND : RUN;
        end
        PEND: if (!tb_busy_i) begin
          r_q.seg_start   <= 1'b1;
          r_q.start_addr  <= r_q.waddr;
          r_q.len         <= FULL;
          r_q.start_state <= r_q.best;
          r_q.dec_end     <= 1'b0;
          r_q.seg         <= '0;
          r_q.state       <= RUN;
        end
        FIN: if (!tb_busy_i) begin
          r_q.seg_start   <= 1'b1;
          r_q.start_addr  <= r_q.waddr;
          r_q.len         <= r_q.fill == FULL ? DEPTH + r_q.seg : r_q.fill;
          r_q.start_state <= '0;
          r_q.dec_end     <= 1'b1;
          r_q.state       <= IDLE;
        end
      endcase
    end
  assign tb_we_o             = r_q.we;
  assign tb_waddr_o          = r_q.waddr;
  assign tb_wdata_o          = r_q.wdata;
  assign segment_start_o     = r_q.seg_start;
  assign tb_start_addr_o     = r_q.start_addr;
  assign tb_len_o            = r_q.len;
  assign start_state_index_o = r_q.start_state;
  assign decoding_end_o      = r_q.dec_end;
  assign register_num_o      = r_q.mode;
  assign frame_done_o        = r_q.done;
`ifdef TB_SURVIVOR_WRITER_STATS_EN
  assign steps_written_o     = r_q.steps;
  assign stall_cycles_o      = r_q.stall;
`endif
endmodule

// File: tb/tb_tb_survivor_writer.sv
// tb_tb_survivor_writer: directed bench for the survivor writer with hand-computed segment schedules
module tb_tb_survivor_writer;
  logic clk = 0, rst_an = 0, rst_sync = 0, frame_start = 0, busy = 0;
  logic [1:0] regnum = 0, regnum_o;
  logic we, seg_start, dec_end, done;
  logic [5:0] waddr, saddr, len, ss;
  logic [63:0] wdata;
`ifdef TB_SURVIVOR_WRITER_STATS_EN
  logic [15:0] steps_w, stall;
`endif
  tb_survivor_writer_if #(.W_DEC(16)) dif();
  tb_survivor_writer dut (
    .clk_i(clk), .rst_an_i(rst_an), .rst_sync_i(rst_sync), .frame_start_i(frame_start),
    .register_num_i(regnum), .dec_if(dif), .tb_busy_i(busy), .tb_we_o(we), .tb_waddr_o(waddr),
    .tb_wdata_o(wdata), .segment_start_o(seg_start), .tb_start_addr_o(saddr), .tb_len_o(len),
    .start_state_index_o(ss), .decoding_end_o(dec_end), .register_num_o(regnum_o), .frame_done_o(done)
`ifdef TB_SURVIVOR_WRITER_STATS_EN
    , .steps_written_o(steps_w), .stall_cycles_o(stall)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0, done_cnt = 0, wr_cnt = 0, seg_cyc = 0, done_cyc = 0, we_cyc = 0;
  logic [63:0] mem [64];
  typedef struct {logic [5:0] addr; logic [5:0] len; logic [5:0] ss; logic e;} seg_t;
  seg_t segs[$];
  // event log sampled 2 time units after each rising edge
  always @(posedge clk) begin
    cyc++;
    #2;
    if (we) begin mem[waddr] = wdata; wr_cnt++; we_cyc = cyc; end
    if (seg_start) begin segs.push_back('{saddr, len, ss, dec_end}); seg_cyc = cyc; end
    if (done) begin done_cnt++; done_cyc = cyc; end
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
  function automatic logic [63:0] pat(input int s);
    return 64'h0123_4567_89AB_CDEF + 64'(s) * 64'h0001_0101_0F0F_1111;
  endfunction
  function automatic logic [63:0] msk(input logic [1:0] m);
    return m == 2'b00 ? '1 : m == 2'b01 ? 64'hFFFF_FFFF : m == 2'b10 ? 64'hFFFF : 64'hFF;
  endfunction
  function automatic int beats(input logic [1:0] m);
    return m == 2'b00 ? 4 : m == 2'b01 ? 2 : 1;
  endfunction
  task automatic clear_log();
    segs.delete();
    foreach (mem[i]) mem[i] = '0;
    wr_cnt = 0;
    done_cnt = 0;
  endtask
  task automatic start_frame(input logic [1:0] m);
    regnum = m;
    frame_start = 1;
    @(negedge clk);
    frame_start = 0;
  endtask
  task automatic send_step(input logic [63:0] p, input int nb, input logic last, input logic [5:0] bs);
    for (int k = 0; k < nb; k++) begin
      int g;
      g = 0;
      dif.dec_valid = 1; dif.dec = p[k*16 +: 16]; dif.best_state = bs; dif.frame_last = last;
      while (!dif.dec_ready && g < 200) begin @(negedge clk); g++; end
      if (g == 200) begin checks++; errors++; $display("FAIL ready_timeout beat %0d", k); end
      @(negedge clk);
    end
    dif.dec_valid = 0;
    dif.frame_last = 0;
  endtask
  task automatic wait_done(input int target);
    int g;
    g = 0;
    while (done_cnt < target && g < 100) begin @(negedge clk); g++; end
    checks++;
    if (done_cnt < target) begin errors++; $display("FAIL frame_done_timeout got %0d want %0d", done_cnt, target); end
    repeat (3) @(negedge clk);
  endtask
  task automatic check_mem(input string nm, input int first, input int last, input int a0, input logic [1:0] m);
    int bad;
    bad = 0;
    for (int s = first; s <= last; s++) if (mem[(a0 + s - first) % 64] !== (pat(s) & msk(m))) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL %s words_wrong got %0d want 0", nm, bad); end
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({we, seg_start, dif.dec_ready, dec_end, done, saddr, len, ss, waddr, regnum_o, wdata} !== '0) begin
      errors++; $display("FAIL reset_outputs got we=%b seg=%b rdy=%b wdata=%h want all 0", we, seg_start, dif.dec_ready, wdata);
    end
    rst_an = 1;
    @(negedge clk);
    checks++;
    if (dif.dec_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %b want 0", dif.dec_ready); end
  endtask
  task automatic test_mode00();
    clear_log();
    start_frame(2'b00);
    for (int s = 1; s <= 40; s++) send_step(pat(s), 4, 0, 6'(s));
    repeat (6) @(negedge clk);
    checks++;
    if (segs.size() != 2 || done_cnt != 0) begin errors++; $display("FAIL m00_mid_segs got %0d/%0d want 2/0", segs.size(), done_cnt); end
    else begin
      checks++;
      if (segs[0].addr !== 6'd31 || segs[0].len !== 6'd32 || segs[0].e !== 1'b0 || segs[0].ss !== 6'd32) begin
        errors++; $display("FAIL m00_seg0 got a=%0d l=%0d e=%b s=%0d want 31 32 0 32", segs[0].addr, segs[0].len, segs[0].e, segs[0].ss);
      end
      checks++;
      if (segs[1].addr !== 6'd39 || segs[1].len !== 6'd32 || segs[1].e !== 1'b0 || segs[1].ss !== 6'd40) begin
        errors++; $display("FAIL m00_seg1 got a=%0d l=%0d e=%b s=%0d want 39 32 0 40", segs[1].addr, segs[1].len, segs[1].e, segs[1].ss);
      end
    end
    send_step(pat(41), 4, 1, 6'd7);
    wait_done(1);
    checks++;
    if (segs.size() != 3 || segs[2].addr !== 6'd40 || segs[2].len !== 6'd25 || segs[2].e !== 1'b1 || segs[2].ss !== 6'd0) begin
      errors++; $display("FAIL m00_fin got n=%0d a=%0d l=%0d e=%b want 3 40 25 1", segs.size(), segs[segs.size()-1].addr, segs[segs.size()-1].len, segs[segs.size()-1].e);
    end
    checks++;
    if (mem[0] !== 64'h0124_4668_98BA_DF00) begin errors++; $display("FAIL m00_word0 got %h want 01244668_98badf00", mem[0]); end
    check_mem("m00", 1, 41, 0, 2'b00);
    checks++;
    if (wr_cnt != 41) begin errors++; $display("FAIL m00_writes got %0d want 41", wr_cnt); end
  endtask
  task automatic test_mode11_short();
    clear_log();
    start_frame(2'b11);
    for (int s = 1; s <= 5; s++) send_step(pat(s), 1, s == 5, 6'h2A);
    wait_done(1);
    checks++;
    if (segs.size() != 1 || segs[0].addr !== 6'd4 || segs[0].len !== 6'd5 || segs[0].e !== 1'b1 || segs[0].ss !== 6'd0) begin
      errors++; $display("FAIL m11_seg got n=%0d a=%0d l=%0d e=%b s=%0d want 1 4 5 1 0", segs.size(), segs[0].addr, segs[0].len, segs[0].e, segs[0].ss);
    end
    check_mem("m11", 1, 5, 0, 2'b11);
    checks++;
    if (wdata[63:8] !== '0) begin errors++; $display("FAIL m11_upper got %h want 0", wdata[63:8]); end
    checks++;
    if (seg_cyc - we_cyc != 1 || done_cyc - seg_cyc != 1) begin
      errors++; $display("FAIL m11_latency got we->seg %0d seg->done %0d want 1 1", seg_cyc - we_cyc, done_cyc - seg_cyc);
    end
    checks++;
    if (regnum_o !== 2'b11) begin errors++; $display("FAIL m11_mode got %b want 11", regnum_o); end
  endtask
  task automatic test_busy();
    int bad;
    bad = 0;
    clear_log();
    busy = 1;
    start_frame(2'b10);
    for (int s = 1; s <= 32; s++) send_step(pat(s), 1, 0, 6'(s));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dif.dec_ready !== 1'b0 || seg_start !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL busy_stall got %0d bad cycles want 0", bad); end
    busy = 0;
    @(negedge clk);
    checks++;
    if (seg_start !== 1'b1 || saddr !== 6'd31 || len !== 6'd32 || ss !== 6'd32) begin
      errors++; $display("FAIL busy_launch got seg=%b a=%0d l=%0d s=%0d want 1 31 32 32", seg_start, saddr, len, ss);
    end
    send_step(pat(33), 1, 0, 6'd33);
    send_step(pat(34), 1, 1, 6'd34);
    wait_done(1);
    check_mem("busy", 1, 34, 0, 2'b10);
    checks++;
    if (wr_cnt != 34 || segs.size() != 2 || segs[1].addr !== 6'd33 || segs[1].len !== 6'd26) begin
      errors++; $display("FAIL busy_fin got w=%0d n=%0d a=%0d l=%0d want 34 2 33 26", wr_cnt, segs.size(), segs[1].addr, segs[1].len);
    end
`ifdef TB_SURVIVOR_WRITER_STATS_EN
    checks++;
    if (steps_w !== 16'd34 || stall !== 16'd10) begin errors++; $display("FAIL stats got %0d/%0d want 34/10", steps_w, stall); end
`endif
  endtask
  task automatic test_wrap();
    clear_log();
    start_frame(2'b10);
    for (int s = 1; s <= 70; s++) send_step(pat(s), 1, s == 70, 6'(s));
    wait_done(1);
    checks++;
    if (segs.size() != 6) begin errors++; $display("FAIL wrap_nseg got %0d want 6", segs.size()); end
    else begin
      checks++;
      if (segs[4].addr !== 6'd63 || segs[4].len !== 6'd32 || segs[4].e !== 1'b0) begin
        errors++; $display("FAIL wrap_seg64 got a=%0d l=%0d e=%b want 63 32 0", segs[4].addr, segs[4].len, segs[4].e);
      end
      checks++;
      if (segs[5].addr !== 6'd5 || segs[5].len !== 6'd30 || segs[5].e !== 1'b1) begin
        errors++; $display("FAIL wrap_fin got a=%0d l=%0d e=%b want 5 30 1", segs[5].addr, segs[5].len, segs[5].e);
      end
    end
    check_mem("wrap_new", 65, 70, 0, 2'b10);
    check_mem("wrap_old", 7, 64, 6, 2'b10);
  endtask
  task automatic test_rst_sync();
    clear_log();
    start_frame(2'b00);
    send_step(pat(100), 2, 0, 6'd1);
    rst_sync = 1;
    @(negedge clk);
    rst_sync = 0;
    checks++;
    if ({we, seg_start, dif.dec_ready, dec_end, done, saddr, len, ss, waddr, regnum_o, wdata} !== '0) begin
      errors++; $display("FAIL rst_sync_outputs got rdy=%b a=%0d l=%0d e=%b want all 0", dif.dec_ready, saddr, len, dec_end);
    end
    start_frame(2'b10);
    send_step(pat(101), 1, 1, 6'd3);
    wait_done(1);
    checks++;
    if (mem[0] !== (pat(101) & 64'hFFFF) || wr_cnt != 1) begin
      errors++; $display("FAIL rst_sync_stale got %h w=%0d want %h 1", mem[0], wr_cnt, pat(101) & 64'hFFFF);
    end
    checks++;
    if (segs.size() != 1 || segs[0].addr !== 6'd0 || segs[0].len !== 6'd1 || segs[0].e !== 1'b1) begin
      errors++; $display("FAIL one_step got n=%0d a=%0d l=%0d e=%b want 1 0 1 1", segs.size(), segs[0].addr, segs[0].len, segs[0].e);
    end
  endtask
  task automatic test_last_at_trigger();
    clear_log();
    start_frame(2'b11);
    for (int s = 1; s <= 16; s++) send_step(pat(s), 1, 0, 6'(s));
    start_frame(2'b00);
    checks++;
    if (regnum_o !== 2'b11) begin errors++; $display("FAIL ignored_start got %b want 11", regnum_o); end
    for (int s = 17; s <= 32; s++) send_step(pat(s), 1, s == 32, 6'(s));
    wait_done(1);
    checks++;
    if (segs.size() != 1 || segs[0].addr !== 6'd31 || segs[0].len !== 6'd32 || segs[0].e !== 1'b1 || segs[0].ss !== 6'd0) begin
      errors++; $display("FAIL last_trig got n=%0d a=%0d l=%0d e=%b want 1 31 32 1", segs.size(), segs[0].addr, segs[0].len, segs[0].e);
    end
    check_mem("last_trig", 1, 32, 0, 2'b11);
  endtask
  initial begin
    dif.dec_valid = 0; dif.dec = '0; dif.best_state = '0; dif.frame_last = 0;
    test_reset();
    test_mode00();
    test_mode11_short();
    test_busy();
    test_wrap();
    test_rst_sync();
    test_last_at_trigger();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
